// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and the IF/ID register of the 5-stage core.
// LDW/SDW with an even Rd are issued twice; the second issue is flagged round2.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  OPC_LDW  = 6'd8,
  parameter logic [5:0]  OPC_SDW  = 6'd9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_round2,
  output logic        if_id_dw_odd
);

  typedef enum logic {FETCH, ROUND2} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        round2;
    logic        dw_odd;
  } if_id_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_inc;
  if_id_t      if_id;
  if_id_t      if_id_nxt;
  logic        dw;
  logic        dw_even;
  logic        dw_odd;

  assign pc_inc  = pc + 32'd4;
  assign dw      = (imem_instr[31:26] == OPC_LDW) ||
                   (imem_instr[31:26] == OPC_SDW);
  assign dw_even = dw && !imem_instr[22];
  assign dw_odd  = dw &&  imem_instr[22];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      if_id <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if_id <= if_id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect_en) begin
      state_nxt = FETCH;
    end else if (!stall) begin
      unique case (state)
        FETCH:   state_nxt = dw_even ? ROUND2 : FETCH;
        ROUND2:  state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // Round 2 replays the word already in IF/ID; imem is not re-read.
  always_comb begin
    pc_nxt    = pc;
    if_id_nxt = if_id;
    if (redirect_en) begin
      pc_nxt           = redirect_pc;
      if_id_nxt.valid  = 1'b0;
      if_id_nxt.instr  = '0;
      if_id_nxt.round2 = 1'b0;
      if_id_nxt.dw_odd = 1'b0;
    end else if (!stall) begin
      unique case (state)
        FETCH: begin
          if_id_nxt.valid    = 1'b1;
          if_id_nxt.instr    = imem_instr;
          if_id_nxt.pc       = pc;
          if_id_nxt.pc_plus4 = pc_inc;
          if_id_nxt.round2   = 1'b0;
          if_id_nxt.dw_odd   = dw_odd;
          if (!dw_even) pc_nxt = pc_inc;
        end
        ROUND2: begin
          if_id_nxt.valid  = 1'b1;
          if_id_nxt.round2 = 1'b1;
          if_id_nxt.dw_odd = 1'b0;
          pc_nxt           = pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr      = pc;
  assign if_id_valid    = if_id.valid;
  assign if_id_instr    = if_id.instr;
  assign if_id_pc       = if_id.pc;
  assign if_id_pc_plus4 = if_id.pc_plus4;
  assign if_id_round2   = if_id.round2;
  assign if_id_dw_odd   = if_id.dw_odd;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage.
// Expected IF/ID snapshots are queued per cycle and popped after each edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_round2;
  logic        if_id_dw_odd;

  logic [31:0] mem [64];
  int          pass  = 0;
  int          total = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        r2;
    logic        odd;
    logic        pcx;
  } exp_t;

  exp_t sb[$];

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_round2   (if_id_round2),
    .if_id_dw_odd   (if_id_dw_odd)
  );

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];

  function automatic logic [31:0] enc(
    input logic [5:0] op, input logic [3:0] rd,
    input logic [3:0] rs, input logic [3:0] rt,
    input logic [13:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  function automatic logic [31:0] filler(input int i);
    return enc(6'd1, 4'd7, 4'd0, 4'd0, 14'(i + 100));
  endfunction

  function automatic exp_t ex(
    input logic [31:0] addr, input logic valid,
    input logic [31:0] instr, input logic [31:0] pc,
    input logic [31:0] pc4, input logic r2,
    input logic odd, input logic pcx);
    return '{addr, valid, instr, pc, pc4, r2, odd, pcx};
  endfunction

  // pc fields are masked when IF/ID was flushed (their contents are unused).
  function automatic exp_t snap(input logic pcx);
    return '{imem_addr, if_id_valid, if_id_instr,
             pcx ? if_id_pc : 32'h0,
             pcx ? if_id_pc_plus4 : 32'h0,
             if_id_round2, if_id_dw_odd, pcx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    exp_t e, o;
    do_reset();
    run(3);
    reset       = 1'b1;
    stall       = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    sb.push_back(ex(32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1));
    tick();
    reset       = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    e = sb.pop_front();
    o = snap(e.pcx);
    total++;
    if (o !== e)
      $display("FAIL reset got %h exp %h", o, e);
    else
      pass++;
  endtask

  task automatic test_free_run();
    exp_t e, o;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex(32'(4 * (i + 1)), 1, mem[i],
                      32'(4 * i), 32'(4 * i + 4), 0, 0, 1));
      tick();
      e = sb.pop_front();
      o = snap(e.pcx);
      total++;
      if (o !== e)
        $display("FAIL free_run[%0d] got %h exp %h", i, o, e);
      else
        pass++;
    end
  endtask

  task automatic test_stall();
    exp_t e, o;
    exp_t x[3];
    x[0] = ex(32'h8, 1, mem[1], 32'h4, 32'h8, 0, 0, 1);
    x[1] = x[0];
    x[2] = ex(32'hC, 1, mem[2], 32'h8, 32'hC, 0, 0, 1);
    do_reset();
    run(2);
    for (int i = 0; i < 3; i++) begin
      stall = (i < 2);
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      o = snap(e.pcx);
      total++;
      if (o !== e)
        $display("FAIL stall[%0d] got %h exp %h", i, o, e);
      else
        pass++;
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect();
    exp_t e, o;
    exp_t x[2];
    x[0] = ex(32'h40, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    x[1] = ex(32'h44, 1, mem[16], 32'h40, 32'h44, 0, 0, 1);
    do_reset();
    run(4);
    for (int i = 0; i < 2; i++) begin
      stall       = (i == 0);
      redirect_en = (i == 0);
      redirect_pc = 32'h40;
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      o = snap(e.pcx);
      total++;
      if (o !== e)
        $display("FAIL redirect[%0d] got %h exp %h", i, o, e);
      else
        pass++;
    end
    stall       = 1'b0;
    redirect_en = 1'b0;
  endtask

  task automatic test_ldw_two_round();
    exp_t e, o;
    exp_t x[3];
    logic [31:0] ldw;
    ldw    = enc(6'd8, 4'd4, 4'd1, 4'd0, 14'd4);
    mem[5] = ldw;
    x[0] = ex(32'h14, 1, ldw, 32'h14, 32'h18, 0, 0, 1);
    x[1] = ex(32'h18, 1, ldw, 32'h14, 32'h18, 1, 0, 1);
    x[2] = ex(32'h1C, 1, mem[6], 32'h18, 32'h1C, 0, 0, 1);
    do_reset();
    run(5);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) mem[5] = 32'hDEAD_BEEF;
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      o = snap(e.pcx);
      total++;
      if (o !== e)
        $display("FAIL ldw[%0d] got %h exp %h", i, o, e);
      else
        pass++;
    end
    mem[5] = filler(5);
  endtask

  task automatic test_ldw_odd();
    exp_t e, o;
    exp_t x[2];
    logic [31:0] ldw;
    ldw    = enc(6'd8, 4'd3, 4'd0, 4'd0, 14'd0);
    mem[4] = ldw;
    x[0] = ex(32'h14, 1, ldw, 32'h10, 32'h14, 0, 1, 1);
    x[1] = ex(32'h18, 1, mem[5], 32'h14, 32'h18, 0, 0, 1);
    do_reset();
    run(4);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      o = snap(e.pcx);
      total++;
      if (o !== e)
        $display("FAIL ldw_odd[%0d] got %h exp %h", i, o, e);
      else
        pass++;
    end
    mem[4] = filler(4);
  endtask

  task automatic test_sdw_abort();
    exp_t e, o;
    exp_t x[3];
    logic [31:0] sdw;
    sdw    = enc(6'd9, 4'd2, 4'd1, 4'd0, 14'd3);
    mem[8] = sdw;
    x[0] = ex(32'h20, 1, sdw, 32'h20, 32'h24, 0, 0, 1);
    x[1] = ex(32'h80, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    x[2] = ex(32'h84, 1, mem[32], 32'h80, 32'h84, 0, 0, 1);
    do_reset();
    run(8);
    for (int i = 0; i < 3; i++) begin
      redirect_en = (i == 1);
      redirect_pc = 32'h80;
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      o = snap(e.pcx);
      total++;
      if (o !== e)
        $display("FAIL sdw_abort[%0d] got %h exp %h", i, o, e);
      else
        pass++;
    end
    redirect_en = 1'b0;
    mem[8] = filler(8);
  endtask

  task automatic test_wrap();
    exp_t e, o;
    exp_t x[2];
    x[0] = ex(32'hFFFF_FFFC, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    x[1] = ex(32'h0, 1, mem[63], 32'hFFFF_FFFC, 32'h0, 0, 0, 1);
    do_reset();
    run(2);
    for (int i = 0; i < 2; i++) begin
      redirect_en = (i == 0);
      redirect_pc = 32'hFFFF_FFFC;
      sb.push_back(x[i]);
      tick();
      e = sb.pop_front();
      o = snap(e.pcx);
      total++;
      if (o !== e)
        $display("FAIL wrap[%0d] got %h exp %h", i, o, e);
      else
        pass++;
    end
    redirect_en = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    for (int i = 0; i < 64; i++) mem[i] = filler(i);
    mem[0] = enc(6'd1, 4'd1, 4'd0, 4'd0, 14'd5);
    mem[1] = enc(6'd1, 4'd2, 4'd0, 4'd0, 14'd10);
    mem[2] = enc(6'd0, 4'd3, 4'd1, 4'd2, 14'd0);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_ldw_two_round();
    test_ldw_odd();
    test_sdw_abort();
    test_wrap();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage pipelined core; sits directly upstream of the instruction memory and downstream of it into the IF/ID register.
- Owns the PC, drives the instruction memory address, and captures the returned word into IF/ID with its PC and PC+4.
- Handles stall, redirect/flush from later stages, and LDW/SDW two-round sequencing: the same instruction is issued twice, the second time flagged round 2.
- Instruction format: opcode[31:26], Rd[25:22], Rs[21:18], Rt[17:14], Imm[13:0].

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (byte address)
OPC_LDW, 6'd8, opcode of load double word
OPC_SDW, 6'd9, opcode of store double word

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; cleared state takes effect at the next rising edge
stall  in  1  hazard unit hold request: PC and IF/ID keep their values
redirect_en  in  1  taken branch/jump/JR/CLL: load redirect_pc, flush IF/ID
redirect_pc  in  32  byte address of the redirect target
imem_addr  out  32  combinational copy of the PC register, to instruction memory
imem_instr  in  32  instruction word returned combinationally for imem_addr
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  captured instruction
if_id_pc  out  32  PC of the captured instruction
if_id_pc_plus4  out  32  if_id_pc + 4, the CLL link value
if_id_round2  out  1  IF/ID holds the second round of LDW/SDW
if_id_dw_odd  out  1  IF/ID holds LDW/SDW with odd Rd (exception flag for later stages)

Behaviour:
- State: pc[31:0], IF/ID register, FSM {FETCH, ROUND2}.
- imem_addr = pc. PC arithmetic is mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- pc bits [1:0] are loaded as given; fetch_stage does not check alignment.
- Reset (synchronous) clears the following at the next edge:
  - pc=RESET_PC, state=FETCH
  - if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, if_id_round2=0, if_id_dw_odd=0
- Per-edge priority: reset > redirect_en > stall > normal.
- redirect_en=1:
  - pc<=redirect_pc; state<=FETCH.
  - IF/ID flushed: valid=0, instr=0, round2=0, dw_odd=0.
  - Applies even when stall=1 in the same cycle.
  - Aborts a pending ROUND2.
- stall=1 (no redirect): pc, state and all IF/ID fields hold.
- FETCH, normal cycle:
  - IF/ID <= {valid=1, instr=imem_instr, pc=pc, pc_plus4=pc+4, round2=0}.
  - dw = (imem_instr[31:26]==OPC_LDW or OPC_SDW).
  - If dw and Rd[22]==0 (even Rd): pc holds; state<=ROUND2.
  - Otherwise pc<=pc+4 and state stays FETCH.
  - If dw and Rd odd: dw_odd=1; no round 2 is issued.
- ROUND2, normal cycle:
  - IF/ID <= same instr and pc as round 1, with round2=1, valid=1, dw_odd=0.
  - pc<=pc+4; state<=FETCH.
  - Round 2 uses the instruction word held in IF/ID, not a re-read of imem.
- Effect on downstream: an LDW/SDW occupies ID for two consecutive non-stalled cycles. Later stages derive Rd+1 and offset+1 from round2.
- Latency: the instruction at pc appears in IF/ID one edge after it is presented.
- Pipeline timing: a redirect asserted in cycle N gives the target in IF/ID after edge N+1. The first valid post-reset instruction appears after the second edge.

Test Plan:
- Reset, then 3 free-running cycles with imem returning ADDI R1,R0,5 / ADDI R2,R0,10 / ADD R3,R1,R2 -> imem_addr 0,4,8,12; IF/ID pc 0,4,8; pc_plus4 4,8,12; valid=1.
- stall=1 for 2 cycles at pc=8 -> imem_addr stays 8; IF/ID holds the pc=4 contents unchanged; resume continues at 8.
- redirect_en=1, redirect_pc=0x40, with stall=1 simultaneously, at pc=0x10 -> next cycle imem_addr=0x40 and if_id_valid=0; following edge if_id_pc=0x40.
- LDW R4,4(R1) at pc=0x14 -> IF/ID shows pc 0x14 with round2=0, then pc 0x14 with round2=1; imem_addr is 0x14,0x14,0x18; next instruction pc=0x18.
- LDW R3,0(R0) (odd Rd) at pc=0x10 -> single issue with dw_odd=1, round2 never set, imem_addr advances to 0x14.
- SDW at pc=0x20, then redirect_en to 0x80 in the ROUND2 cycle -> round2 is never issued; IF/ID flushed; next fetch at 0x80 in state FETCH. Also: pc=0xFFFF_FFFC normal cycle -> imem_addr wraps to 0.
